// File: rtl/crt_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 scan and the 4:4:4 colour type.
package crt_timing_pkg;

  localparam int CRT_H_VISIBLE = 640;
  localparam int CRT_H_FRONT   = 16;
  localparam int CRT_H_SYNC    = 96;
  localparam int CRT_H_BACK    = 48;
  localparam int CRT_V_VISIBLE = 480;
  localparam int CRT_V_FRONT   = 10;
  localparam int CRT_V_SYNC    = 2;
  localparam int CRT_V_BACK    = 33;

  localparam int CRT_H_TOTAL = CRT_H_VISIBLE + CRT_H_FRONT + CRT_H_SYNC + CRT_H_BACK;
  localparam int CRT_V_TOTAL = CRT_V_VISIBLE + CRT_V_FRONT + CRT_V_SYNC + CRT_V_BACK;

  localparam int CRT_HS_START = CRT_H_VISIBLE + CRT_H_FRONT;
  localparam int CRT_HS_END   = CRT_HS_START + CRT_H_SYNC - 1;
  localparam int CRT_VS_START = CRT_V_VISIBLE + CRT_V_FRONT;
  localparam int CRT_VS_END   = CRT_VS_START + CRT_V_SYNC - 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/crt_delay_line.sv
// Fixed-depth shift register with async reset to a chosen value; DEPTH=0 is a wire.
module crt_delay_line
  import crt_timing_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk25,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk25 ^ Reset;
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/crt_timing_driver.sv
// VGA raster generator: free-running scan counters, frame tick, and an output stage that
// blanks colour and aligns it with hsync/vsync after the game's pixel latency.
module crt_timing_driver
  import crt_timing_pkg::*;
#(
  parameter int   H_VISIBLE     = CRT_H_VISIBLE,
  parameter int   H_FRONT       = CRT_H_FRONT,
  parameter int   H_SYNC        = CRT_H_SYNC,
  parameter int   H_BACK        = CRT_H_BACK,
  parameter int   V_VISIBLE     = CRT_V_VISIBLE,
  parameter int   V_FRONT       = CRT_V_FRONT,
  parameter int   V_SYNC        = CRT_V_SYNC,
  parameter int   V_BACK        = CRT_V_BACK,
  parameter logic SYNC_ACTIVE   = 1'b0,
  parameter int   PIXEL_LATENCY = 0
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [3:0] vga_red,
  output logic [3:0] vga_green,
  output logic [3:0] vga_blue
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       vis0, hs0, vs0;
  logic [2:0] tim_d;
  rgb444_t    pix_q;

  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign xpos = h_cnt;
  assign ypos = v_cnt;

  assign vis0 = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
  assign hs0  = (h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END));
  assign vs0  = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));

  // Timing flags wait here for the game's colour, which arrives PIXEL_LATENCY clocks late.
  crt_delay_line #(
    .WIDTH       (3),
    .DEPTH       (PIXEL_LATENCY),
    .RESET_VALUE (3'b000)
  ) u_delay (
    .clk25 (clk25),
    .Reset (Reset),
    .d     ({vis0, hs0, vs0}),
    .q     (tim_d)
  );

  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      pix_q      <= '0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      frame_tick <= 1'b0;
    end else begin
      pix_q      <= tim_d[2] ? rgb444_t'({red_in, green_in, blue_in}) : '0;
      video_on   <= tim_d[2];
      hsync      <= tim_d[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync      <= tim_d[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_tick <= (h_cnt == '0) && (v_cnt == 10'(V_VISIBLE));
    end
  end

  assign vga_red   = pix_q.r;
  assign vga_green = pix_q.g;
  assign vga_blue  = pix_q.b;

endmodule

// File: tb/tb_crt_timing_driver.sv
// Bench for crt_timing_driver: a full-size 640x480 instance (latency 0) and a shrunken
// raster instance (latency 2) checked cycle by cycle against a scoreboard of expected outputs.
module tb_crt_timing_driver;

  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int AHT = 800, AVT = 525, APL = 0;

  localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 3;
  localparam int BVV = 12, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = 25, BVT = 19, BPL = 2;

  typedef struct packed {
    logic        vis;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic       clk25 = 1'b0;
  logic       Reset = 1'b1;

  logic [3:0] a_red, a_green, a_blue, a_vga_red, a_vga_green, a_vga_blue;
  logic [9:0] a_xpos, a_ypos;
  logic       a_frame_tick, a_hsync, a_vsync, a_video_on;
  logic [3:0] b_red, b_green, b_blue, b_vga_red, b_vga_green, b_vga_blue;
  logic [9:0] b_xpos, b_ypos;
  logic       b_frame_tick, b_hsync, b_vsync, b_video_on;

  int checks = 0;
  int errors = 0;

  int   ax, ay, bx, by;
  logic a_tick_exp, b_tick_exp;
  exp_t qa[$];
  exp_t qb[$];
  logic [11:0] bcol[$];
  int a_hs_cnt, a_vis_cnt, b_hs_cnt, b_vis_cnt, b_len, b_vs_cnt;
  logic b_seen_tick;

  always #20 clk25 = ~clk25;

  crt_timing_driver #(
    .H_VISIBLE(AHV), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_VISIBLE(AVV), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB),
    .SYNC_ACTIVE(1'b0), .PIXEL_LATENCY(APL)
  ) dut_a (
    .clk25(clk25), .Reset(Reset),
    .red_in(a_red), .green_in(a_green), .blue_in(a_blue),
    .xpos(a_xpos), .ypos(a_ypos), .frame_tick(a_frame_tick),
    .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
    .vga_red(a_vga_red), .vga_green(a_vga_green), .vga_blue(a_vga_blue)
  );

  crt_timing_driver #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .SYNC_ACTIVE(1'b0), .PIXEL_LATENCY(BPL)
  ) dut_b (
    .clk25(clk25), .Reset(Reset),
    .red_in(b_red), .green_in(b_green), .blue_in(b_blue),
    .xpos(b_xpos), .ypos(b_ypos), .frame_tick(b_frame_tick),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
    .vga_red(b_vga_red), .vga_green(b_vga_green), .vga_blue(b_vga_blue)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int x, input int y, input int hv, input int hf,
                                  input int hs, input int vv, input int vf, input int vs,
                                  input logic [11:0] col);
    exp_t e;
    e.vis = (x < hv) && (y < vv);
    e.hs  = (x >= hv + hf) && (x < hv + hf + hs);
    e.vs  = (y >= vv + vf) && (y < vv + vf + vs);
    e.rgb = e.vis ? col : 12'h000;
    return e;
  endfunction

  // Game model for A: white in the visible area, 0xA everywhere in blanking.
  function automatic logic [11:0] col_a(input int x, input int y);
    return ((x < AHV) && (y < AVV)) ? 12'hFFF : 12'hAAA;
  endfunction

  function automatic logic [11:0] col_b(input int x, input int y);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    return {xv[3:0], ~xv[3:0], yv[3:0]};
  endfunction

  task automatic drive();
    {a_red, a_green, a_blue} = col_a(ax, ay);
    bcol.push_back(col_b(bx, by));
    {b_red, b_green, b_blue} = bcol.pop_front();
  endtask

  task automatic init_models();
    ax = 0; ay = 0; bx = 0; by = 0;
    qa.delete(); qb.delete(); bcol.delete();
    repeat (APL + 1) qa.push_back('0);
    repeat (BPL + 1) qb.push_back('0);
    repeat (BPL) bcol.push_back(12'h000);
    a_tick_exp = 1'b0; b_tick_exp = 1'b0;
    a_hs_cnt = 0; a_vis_cnt = 0; b_hs_cnt = 0; b_vis_cnt = 0;
    b_len = 0; b_vs_cnt = 0; b_seen_tick = 1'b0;
    drive();
  endtask

  task automatic chk_reset_values(input string who);
    chk({who, "_rst_pos_a"}, {a_ypos, a_xpos}, 20'h0);
    chk({who, "_rst_pos_b"}, {b_ypos, b_xpos}, 20'h0);
    chk({who, "_rst_out_a"}, {a_video_on, a_hsync, a_vsync, a_vga_red, a_vga_green, a_vga_blue, a_frame_tick},
        {1'b0, 1'b1, 1'b1, 12'h000, 1'b0});
    chk({who, "_rst_out_b"}, {b_video_on, b_hsync, b_vsync, b_vga_red, b_vga_green, b_vga_blue, b_frame_tick},
        {1'b0, 1'b1, 1'b1, 12'h000, 1'b0});
  endtask

  task automatic release_reset();
    @(posedge clk25);
    #1;
    Reset = 1'b0;
    init_models();
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk25);
    chk("a_pos", {a_ypos, a_xpos}, {10'(ay), 10'(ax)});
    chk("b_pos", {b_ypos, b_xpos}, {10'(by), 10'(bx)});
    e = qa.pop_front();
    chk("a_out", {a_video_on, ~a_hsync, ~a_vsync, a_vga_red, a_vga_green, a_vga_blue}, e);
    e = qb.pop_front();
    chk("b_out", {b_video_on, ~b_hsync, ~b_vsync, b_vga_red, b_vga_green, b_vga_blue}, e);
    qa.push_back(mk_exp(ax, ay, AHV, AHF, AHS, AVV, AVF, AVS, col_a(ax, ay)));
    qb.push_back(mk_exp(bx, by, BHV, BHF, BHS, BVV, BVF, BVS, col_b(bx, by)));
    chk("a_tick", a_frame_tick, a_tick_exp);
    chk("b_tick", b_frame_tick, b_tick_exp);

    a_hs_cnt  += (a_hsync == 1'b0) ? 1 : 0;
    a_vis_cnt += a_video_on ? 1 : 0;
    if (ax == AHT - 1) begin
      chk("a_hs_per_line", a_hs_cnt, AHS);
      chk("a_vis_per_line", a_vis_cnt, (ay < AVV) ? AHV : 0);
      a_hs_cnt = 0; a_vis_cnt = 0;
    end
    b_hs_cnt  += (b_hsync == 1'b0) ? 1 : 0;
    b_vis_cnt += b_video_on ? 1 : 0;
    if (bx == BHT - 1) begin
      chk("b_hs_per_line", b_hs_cnt, BHS);
      chk("b_vis_per_line", b_vis_cnt, (by < BVV) ? BHV : 0);
      b_hs_cnt = 0; b_vis_cnt = 0;
    end
    if (b_frame_tick) begin
      if (b_seen_tick) begin
        chk("b_frame_len", b_len, BHT * BVT);
        chk("b_vs_per_frame", b_vs_cnt, BVS * BHT);
      end
      b_seen_tick = 1'b1;
      b_len = 0; b_vs_cnt = 0;
    end
    b_len++;
    b_vs_cnt += (b_vsync == 1'b0) ? 1 : 0;

    @(posedge clk25);
    #1;
    a_tick_exp = (ax == 0) && (ay == AVV);
    b_tick_exp = (bx == 0) && (by == BVV);
    if (ax == AHT - 1) begin ax = 0; ay = (ay == AVT - 1) ? 0 : ay + 1; end
    else ax++;
    if (bx == BHT - 1) begin bx = 0; by = (by == BVT - 1) ? 0 : by + 1; end
    else bx++;
    drive();
  endtask

  initial begin
    {a_red, a_green, a_blue} = 12'h000;
    {b_red, b_green, b_blue} = 12'h000;
    repeat (3) @(posedge clk25);
    #1;
    chk_reset_values("init");
    release_reset();
    repeat (5000) step();

    // Asynchronous reset in the middle of a line and part-way through a B frame.
    @(negedge clk25);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_values("mid");
    release_reset();
    repeat (AHT * 40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crt_timing_driver.md
Name: crt_timing_driver

Overview:
- Produces the raster scan (xpos, ypos) consumed by the game/rendering logic. Receives that logic's 4-bit-per-channel colour back.
- Generates 640x480@60 Hz VGA sync from clk25.
- Blanks the colour outside the visible area and time-aligns colour, hsync and vsync at the output pins.
- Sits between the top level and the game module. Also supplies a once-per-frame tick for game-state updates.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
PIXEL_LATENCY, 0, clocks from xpos/ypos change to matching colour at red_in/green_in/blue_in (legal range 0..3)

Ports:
clk25  input  1  25 MHz pixel clock
Reset  input  1  asynchronous, active-high reset
red_in  input  4  red from game logic
green_in  input  4  green from game logic
blue_in  input  4  blue from game logic
xpos  output  10  current horizontal count, 0..799
ypos  output  10  current vertical count, 0..524
frame_tick  output  1  one-clock pulse at start of vertical blank
hsync  output  1  horizontal sync to connector
vsync  output  1  vertical sync to connector
video_on  output  1  high while output pixel is visible, aligned with vga_* outputs
vga_red  output  4  blanked, registered red to connector
vga_green  output  4  blanked, registered green
vga_blue  output  4  blanked, registered blue

Behaviour:
- Derived constants: H_TOTAL = 800 (sum of the H_* parameters); V_TOTAL = 525 (sum of the V_* parameters).
- h_cnt increments every clk25 and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on an h_cnt wrap, and wraps V_TOTAL-1 -> 0 on the same edge that h_cnt wraps.
- xpos/ypos are the counter registers themselves, with no extra latency. They run through the blanking region (xpos 640..799, ypos 480..524). The game must tolerate these values; the output stage masks them.
- Raw timing signals at counter time (stage 0):
  - vis0 = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs0 asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]
  - vs0 asserted for v_cnt in [490,491], across the entire lines
- vis0/hs0/vs0 pass through a PIXEL_LATENCY-deep delay line, then one output register.
  - red_in/green_in/blue_in (already PIXEL_LATENCY late) are sampled only by the output register.
  - All vga_*, hsync, vsync and video_on therefore change together, PIXEL_LATENCY+1 clocks after the counter state they describe.
- Output register: vga_* = delayed_vis ? *_in : 4'h0; video_on = delayed_vis; hsync/vsync = SYNC_ACTIVE when the delayed hs/vs is asserted, otherwise ~SYNC_ACTIVE.
- frame_tick is registered high for exactly one clock, in the cycle after the counters read h_cnt==0 and v_cnt==V_VISIBLE. It is not delayed by PIXEL_LATENCY and fires once per frame.
- Reset (async assert, released synchronously by the top level):
  - h_cnt=0, v_cnt=0
  - all delay-line stages cleared to not-visible / sync-inactive
  - vga_*=0, video_on=0, hsync=vsync=~SYNC_ACTIVE, frame_tick=0
  - The first clock after release shows xpos=0, ypos=0.
- Reset mid-frame: takes effect immediately. The frame is restarted from (0,0) and no partial sync pulse is extended.
- No other control states. The block free-runs; there is no enable and no back-pressure.

Decomposition:
- Package crt_timing_pkg holds:
  - the timing constants and derived H_TOTAL/V_TOTAL, plus the sync start/end constants
  - a 12-bit rgb444 typedef used by this block and the game
- One sub-module: crt_delay_line (WIDTH, DEPTH; DEPTH=0 is a pass-through), async reset to a parameterised RESET_VALUE. It delays {vis, hs, vs}.

Test Plan:
1. Reset asserted mid-line, then released -> outputs at reset values immediately; first clock after release xpos=0, ypos=0; hsync=vsync=1.
2. Free-run one full frame -> xpos wraps 799->0 with ypos incrementing; ypos wraps 524->0; exactly 420000 clocks per frame; exactly one frame_tick, seen the clock after (xpos=0, ypos=480).
3. PIXEL_LATENCY=0, red_in=green_in=blue_in=4'hF -> hsync low for exactly 96 clocks per line, starting 1 clock after xpos=656. vsync low for lines 490-491 (1600 clocks). video_on/vga_*=F for 640 clocks per line, 0 otherwise.
4. PIXEL_LATENCY=2, model driving colour = xpos[3:0] delayed 2 clocks -> vga_red at the first visible output pixel is 0 and increments each clock; hsync edge moves 2 clocks later than in scenario 3; no colour shows during blanking.
5. Colour forced to 4'hA during rows 480..524 and columns 640..799 -> vga_* stay 0 throughout, video_on=0.
